// File: rtl/bram_resp.sv
// rtl/bram_resp.sv - EBR-backed read/write responder with post-reset zero sweep.
// Optional same-cycle write-to-read forwarding: define BRAM_RESP_RAW_FWD_EN.
module bram_resp #(
  parameter int DATA_SZ = 16,
  parameter int ADDR_SZ = 8,
  parameter int DEPTH   = 1 << ADDR_SZ
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_wr_en,
  input  logic [ADDR_SZ-1:0] i_waddr,
  input  logic [DATA_SZ-1:0] i_wdata,
  input  logic               i_rd_en,
  input  logic [ADDR_SZ-1:0] i_raddr,
  output logic [DATA_SZ-1:0] o_rdata,
  output logic               o_rvalid,
  output logic               o_ready,
  output logic               o_err
);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [ADDR_SZ-1:0] cnt;
  logic               mem_we;
  logic [ADDR_SZ-1:0] mem_wa;
  logic [DATA_SZ-1:0] mem_wd;
  logic               rd_acc;
  logic               req_in_clear;
  logic [DATA_SZ-1:0] ram_q;
  logic               have_data;
  logic [DATA_SZ-1:0] mem [DEPTH];

  // State register and sweep counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR)
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (cnt == ADDR_SZ'(DEPTH - 1)) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    o_ready      = (state == RUN);
    rd_acc       = o_ready && i_rd_en;
    req_in_clear = !o_ready && (i_wr_en || i_rd_en);
    mem_we       = 1'b0;
    mem_wa       = i_waddr;
    mem_wd       = i_wdata;
    if (state == CLEAR) begin
      mem_we = 1'b1;
      mem_wa = cnt;
      mem_wd = '0;
    end else if (i_wr_en) begin
      mem_we = 1'b1;
    end
  end

  // Unreset array and read register so the pair maps onto one EBR (read-first)
  always_ff @(posedge i_clk) begin
    if (mem_we)
      mem[mem_wa] <= mem_wd;
    if (rd_acc)
      ram_q <= mem[i_raddr];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rvalid  <= 1'b0;
      have_data <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_rvalid <= rd_acc;
      if (rd_acc)
        have_data <= 1'b1;
      if (req_in_clear)
        o_err <= 1'b1;
    end
  end

`ifdef BRAM_RESP_RAW_FWD_EN
  logic               fwd_hit;
  logic [DATA_SZ-1:0] fwd_data;

  // Captured only on accepted reads so the held o_rdata stays consistent
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fwd_hit  <= 1'b0;
      fwd_data <= '0;
    end else if (rd_acc) begin
      fwd_hit  <= i_wr_en && (i_waddr == i_raddr);
      fwd_data <= i_wdata;
    end
  end

  always_comb begin
    o_rdata = '0;
    if (have_data)
      o_rdata = fwd_hit ? fwd_data : ram_q;
  end
`else
  always_comb begin
    o_rdata = '0;
    if (have_data)
      o_rdata = ram_q;
  end
`endif

endmodule

// File: tb/tb_bram_resp.sv
// tb/tb_bram_resp.sv - directed table-driven bench for bram_resp.
module tb_bram_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  waddr = '0;
  logic [15:0] wdata = '0;
  logic        rd_en = 1'b0;
  logic [7:0]  raddr = '0;
  logic [15:0] rdata;
  logic        rvalid;
  logic        ready;
  logic        err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bram_resp dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_wr_en (wr_en),
    .i_waddr (waddr),
    .i_wdata (wdata),
    .i_rd_en (rd_en),
    .i_raddr (raddr),
    .o_rdata (rdata),
    .o_rvalid(rvalid),
    .o_ready (ready),
    .o_err   (err)
  );

  typedef struct packed {
    logic        wr;
    logic [7:0]  wa;
    logic [15:0] wd;
    logic        rd;
    logic [7:0]  ra;
    logic        exp_rvalid;
    logic [15:0] exp_rdata;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

`ifdef BRAM_RESP_RAW_FWD_EN
  localparam logic [15:0] RAW_EXP = 16'hDEAD;
`else
  localparam logic [15:0] RAW_EXP = 16'hFADE;
`endif

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [7:0] wa, input logic [15:0] wd,
                       input logic r, input logic [7:0] ra);
    wr_en = w; waddr = wa; wdata = wd; rd_en = r; raddr = ra;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until o_ready rises; optionally inject a request mid-sweep
  task automatic sweep(input string name, input bit inject);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    drive(0, 8'h00, 16'h0000, 0, 8'h00);
    for (int i = 0; i < 300 && !seen; i++) begin
      if (inject && i == 5) drive(1, 8'h10, 16'h1234, 1, 8'h10);
      tick();
      n++;
      if (inject && i == 5) begin
        drive(0, 8'h00, 16'h0000, 0, 8'h00);
        check({name, "_err_set"}, {15'd0, err}, 16'd1);
        check({name, "_no_rvalid"}, {15'd0, rvalid}, 16'd0);
      end
      if (ready) seen = 1;
    end
    check({name, "_sweep_len"}, 16'(n), 16'd256);
  endtask

  task automatic run_vec(input int i);
    drive(vecs[i].wr, vecs[i].wa, vecs[i].wd, vecs[i].rd, vecs[i].ra);
    tick();
    check($sformatf("vec%0d_rvalid", i), {15'd0, rvalid}, {15'd0, vecs[i].exp_rvalid});
    check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
    check($sformatf("vec%0d_ready", i), {15'd0, ready}, 16'd1);
  endtask

  initial begin
    //           wr  wa     wd         rd  ra     rv  rdata
    vecs[0]  = {1'b0, 8'h00, 16'h0000, 1'b1, 8'h95, 1'b1, 16'h0000};
    vecs[1]  = {1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h0000};
    vecs[2]  = {1'b1, 8'hFF, 16'hBE11, 1'b0, 8'h00, 1'b0, 16'h0000};
    vecs[3]  = {1'b1, 8'h95, 16'hC0DE, 1'b0, 8'h00, 1'b0, 16'h0000};
    vecs[4]  = {1'b0, 8'h00, 16'h0000, 1'b1, 8'hFF, 1'b1, 16'hBE11};
    vecs[5]  = {1'b0, 8'h00, 16'h0000, 1'b1, 8'h95, 1'b1, 16'hC0DE};
    vecs[6]  = {1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 16'hC0DE};
    vecs[7]  = {1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 16'hC0DE};
    vecs[8]  = {1'b1, 8'hFF, 16'hFADE, 1'b1, 8'h95, 1'b1, 16'hC0DE};
    vecs[9]  = {1'b0, 8'h00, 16'h0000, 1'b1, 8'hFF, 1'b1, 16'hFADE};
    vecs[10] = {1'b1, 8'hFF, 16'hDEAD, 1'b1, 8'hFF, 1'b1, RAW_EXP};
    vecs[11] = {1'b0, 8'h00, 16'h0000, 1'b1, 8'hFF, 1'b1, 16'hDEAD};
    vecs[12] = {1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 16'hDEAD};
    vecs[13] = {1'b1, 8'h30, 16'h1111, 1'b0, 8'h00, 1'b0, 16'hDEAD};
    vecs[14] = {1'b0, 8'h00, 16'h0000, 1'b1, 8'h30, 1'b1, 16'h1111};

    repeat (3) tick();
    check("rst_ready", {15'd0, ready}, 16'd0);
    check("rst_rvalid", {15'd0, rvalid}, 16'd0);
    check("rst_rdata", rdata, 16'h0000);
    check("rst_err", {15'd0, err}, 16'd0);

    rst_n = 1'b1;
    sweep("first", 0);
    check("first_err_clean", {15'd0, err}, 16'd0);

    for (int i = 0; i < NV; i++) run_vec(i);
    check("run_err_clean", {15'd0, err}, 16'd0);

    // Reset the cycle after a read: outputs must drop without a clock edge
    drive(0, 8'h00, 16'h0000, 1, 8'hFF);
    tick();
    drive(0, 8'h00, 16'h0000, 0, 8'h00);
    check("pre_rst_rvalid", {15'd0, rvalid}, 16'd1);
    check("pre_rst_rdata", rdata, 16'hDEAD);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid", {15'd0, rvalid}, 16'd0);
    check("mid_rst_rdata", rdata, 16'h0000);
    check("mid_rst_ready", {15'd0, ready}, 16'd0);
    check("mid_rst_err", {15'd0, err}, 16'd0);
    repeat (2) tick();
    rst_n = 1'b1;

    sweep("second", 1);
    check("second_err_sticky", {15'd0, err}, 16'd1);

    drive(0, 8'h00, 16'h0000, 1, 8'h10);
    tick();
    check("clear_req_ignored", rdata, 16'h0000);
    check("clear_req_rvalid", {15'd0, rvalid}, 16'd1);
    drive(0, 8'h00, 16'h0000, 1, 8'hFF);
    tick();
    check("resweep_ff", rdata, 16'h0000);
    drive(0, 8'h00, 16'h0000, 0, 8'h00);
    tick();
    check("final_rvalid", {15'd0, rvalid}, 16'd0);
    check("final_err_sticky", {15'd0, err}, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_resp.md
Name: bram_resp

Overview:
- Memory-side responder for the split read/write port protocol used by the BRAM test fixtures and the allocator.
- Owns a DEPTH x DATA_SZ array built on iCE40 EBR.
- After reset it zero-fills the whole array before accepting requests, so the initiator never needs an ad-hoc start-up delay.
- Serves one write and one read per cycle, with 1-cycle read latency, a read-valid strobe and a sticky protocol-error flag.

Parameters:
- DATA_SZ, 16, data word width in bits.
- ADDR_SZ, 8, address width in bits.
- DEPTH, 1<<ADDR_SZ, number of words; must equal 2**ADDR_SZ.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_wr_en  in  1  write request this cycle.
- i_waddr  in  ADDR_SZ  write address.
- i_wdata  in  DATA_SZ  write data.
- i_rd_en  in  1  read request this cycle.
- i_raddr  in  ADDR_SZ  read address.
- o_rdata  out  DATA_SZ  read data; held until the next accepted read.
- o_rvalid  out  1  one-cycle strobe: o_rdata carries the result of the read accepted on the previous cycle.
- o_ready  out  1  high when requests are accepted.
- o_err  out  1  sticky: a request arrived while o_ready was low.

Behaviour:
- Reset (async assert, sync release): state=CLEAR, clear counter=0, o_rdata=0, o_rvalid=0, o_ready=0, o_err=0. Array contents are not reset directly; the CLEAR sweep zeroes them.
- State machine, 2 states:
  - CLEAR: write 0 to address = counter each cycle, counter+1. After the write to DEPTH-1, go to RUN. The sweep takes exactly DEPTH cycles.
  - RUN: o_ready=1. Stays in RUN until reset.
- Requests in CLEAR (i_wr_en or i_rd_en high):
  - ignored, with no array write and no o_rvalid;
  - o_err set to 1 and held until reset.
- Write in RUN: mem[i_waddr] <= i_wdata at the clock edge.
- Read in RUN: on the edge where i_rd_en=1, capture mem[i_raddr]. On the next cycle o_rdata shows the value and o_rvalid=1.
- Read latency is exactly 1 cycle. Back-to-back reads on consecutive cycles each produce a strobe.
- When no read is accepted: o_rvalid=0 and o_rdata keeps its last value.
- Write then read of the same address on the next cycle returns the new data; no hazard.
- Same-cycle write and read to the same address: result depends on RAW_FWD_EN (see below).
- Same-cycle write and read to different addresses: independent.
- Address wrap: none. Addresses are exactly ADDR_SZ bits and all DEPTH locations are valid.
- Reset asserted mid-sweep or mid-RUN: returns immediately to CLEAR, counter=0, outputs as at reset. Any pending read result is discarded (o_rvalid=0).

Optional Feature:
- Macro: BRAM_RESP_RAW_FWD_EN.
- Defined: for a same-cycle write and read to the same address, o_rdata on the next cycle is i_wdata (new data). Implement with a registered compare of the two addresses plus a mux; the EBR itself stays read-first.
- Undefined: the same case returns the old array contents (read-first). No forwarding logic is built.
- All other behaviour is identical either way.

Test Plan:
- Reset, then hold i_wr_en=i_rd_en=0 -> o_ready stays 0 for exactly 256 cycles (default params) and rises on cycle 257. Then read addr 8'h95 -> o_rvalid pulses and o_rdata=16'h0000.
- In RUN, write 8'hFF=16'hBE11 and 8'h95=16'hC0DE, then read 8'hFF and 8'h95 back-to-back -> o_rvalid high two cycles, o_rdata=16'hBE11 then 16'hC0DE. o_rdata is held after the strobes.
- Same cycle: write 8'hFF=16'hFADE and read 8'h95 -> next cycle o_rdata=16'hC0DE. A follow-up read of 8'hFF -> 16'hFADE.
- Same cycle: write 8'hFF=16'hDEAD and read 8'hFF:
  - with RAW_FWD_EN -> 16'hDEAD;
  - without -> 16'hFADE;
  - in both builds, the next read of 8'hFF -> 16'hDEAD.
- Assert i_wr_en (addr 8'h10, data 16'h1234) during CLEAR -> o_err=1 and stays 1. After the sweep, reading 8'h10 -> 16'h0000.
- Pulse i_rst_n low mid-RUN, including the cycle after a read -> o_rvalid=0, o_rdata=0 and o_ready=0 immediately. A full 256-cycle sweep reruns, and 8'hFF then reads 16'h0000.
